centroid_marker: RTL and testbench

- Pixel-stream stage directly downstream of the LUT stage (vp_0); consumes its binary-mask output.
- Accumulates the mask moments m00, m10 and m01 over each frame. At frame end it computes the centroid with a sequential divider.
- In the following frames it overlays a crosshair at the centroid on the passed-through video, then feeds hdmi_out.

---
 rtl/centroid_marker.sv | 218 +++++++++++++++++++++
 tb/tb_centroid_marker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_marker.sv
// centroid_marker
// Tracks the centroid of the binary mask produced by the LUT stage and
// overlays a crosshair at the last valid centroid on the passed-through video.
// Moments m00/m10/m01 are accumulated per frame. At frame end they are
// snapshotted, and a shared restoring divider computes x = m10/m00, then
// y = m01/m00.
//
// Ports
//   clk, rst                 pixel clock, async active-high reset
//   de_in/h_sync_in/v_sync_in/pixel_in    video from the LUT stage
//   de_out/h_sync_out/v_sync_out/pixel_out    same video one clock later,
//                                             with the crosshair applied
//   centroid_x/centroid_y    last committed centroid
//   centroid_valid           centroid_x/y hold a valid (non-empty) result
//
// FSM states
//   state  | meaning
//   IDLE   | wait for a frame end
//   CHECK  | empty-frame test, load divider with m10
//   DIV_X  | m10/m00, one quotient bit per cycle
//   DIV_Y  | m01/m00, one quotient bit per cycle
//   UPDATE | commit centroid (or invalidate on an empty frame)
module centroid_marker #(
    parameter int          IMG_W      = 64,
    parameter int          IMG_H      = 64,
    parameter int          XY_W       = 11,
    parameter int          ACC_W      = 34,
    parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            de_in,
    input  logic            h_sync_in,
    input  logic            v_sync_in,
    input  logic [23:0]     pixel_in,
    output logic            de_out,
    output logic            h_sync_out,
    output logic            v_sync_out,
    output logic [23:0]     pixel_out,
    output logic [XY_W-1:0] centroid_x,
    output logic [XY_W-1:0] centroid_y,
    output logic            centroid_valid
);

    typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, UPDATE} state_t;

    localparam int               CNT_W    = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_W - 1);

    state_t           state, state_nxt;
    logic             de_q, hs_q, vs_q, vs_q2;
    logic [23:0]      pix_q;
    logic [XY_W-1:0]  x, y;
    logic [ACC_W-1:0] m00, m10, m01;
    logic [ACC_W-1:0] sh_m00, sh_m10, sh_m01;
    logic             armed, zero_flag;
    logic [ACC_W-1:0] quo, rem;
    logic [CNT_W-1:0] cnt;
    logic [XY_W-1:0]  qx;
    logic [XY_W-1:0]  cx, cy;
    logic             cvalid;

    logic             frame_end, start, de_fall, in_area, hit, overlay;
    logic [ACC_W:0]   trial;
    logic             ge;
    logic [ACC_W-1:0] diff, rem_nxt, quo_nxt;

    // Frame end is taken from the registered v_sync so every reaction to it
    // lines up with the 1-clock output pipeline.
    assign frame_end = vs_q & ~vs_q2;
    assign start     = frame_end & armed;
    assign de_fall   = de_q & ~de_in;
    // Pixels outside the nominal active area (malformed timing) are not
    // accumulated, so a long line cannot skew the moments.
    assign in_area   = (x < XY_W'(IMG_W)) && (y < XY_W'(IMG_H));
    assign hit       = de_in && (pixel_in != 24'd0) && in_area;
    assign overlay   = de_in && cvalid && ((x == cx) || (y == cy));

    // Restoring divide step: shift the next dividend bit into the remainder.
    // When ge is set the true difference is below the divisor, so the
    // ACC_W-bit subtraction cannot wrap.
    assign trial   = {rem, quo[ACC_W-1]};
    assign ge      = trial >= {1'b0, sh_m00};
    assign diff    = trial[ACC_W-1:0] - sh_m00;
    assign rem_nxt = ge ? diff : trial[ACC_W-1:0];
    assign quo_nxt = {quo[ACC_W-2:0], ge};

    assign de_out         = de_q;
    assign h_sync_out     = hs_q;
    assign v_sync_out     = vs_q;
    assign pixel_out      = pix_q;
    assign centroid_x     = cx;
    assign centroid_y     = cy;
    assign centroid_valid = cvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            pix_q <= 24'd0;
        end else begin
            de_q  <= de_in;
            hs_q  <= h_sync_in;
            vs_q  <= v_sync_in;
            vs_q2 <= vs_q;
            pix_q <= overlay ? MARK_COLOR : pixel_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            m00    <= '0;
            m10    <= '0;
            m01    <= '0;
            sh_m00 <= '0;
            sh_m10 <= '0;
            sh_m01 <= '0;
            armed  <= 1'b0;
        end else if (frame_end) begin
            x     <= '0;
            y     <= '0;
            m00   <= '0;
            m10   <= '0;
            m01   <= '0;
            armed <= 1'b1;
            if (armed) begin
                sh_m00 <= m00;
                sh_m10 <= m10;
                sh_m01 <= m01;
            end
        end else begin
            if (de_in) begin
                x <= x + 1'b1;
            end else if (de_fall) begin
                x <= '0;
                y <= y + 1'b1;
            end
            if (hit) begin
                m00 <= m00 + 1'b1;
                m10 <= m10 + ACC_W'(x);
                m01 <= m01 + ACC_W'(y);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            CHECK:   state_nxt = (sh_m00 == '0) ? UPDATE : DIV_X;
            DIV_X:   if (cnt == '0) state_nxt = DIV_Y;
            DIV_Y:   if (cnt == '0) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A new frame end restarts the computation from any state.
        if (start) state_nxt = CHECK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            qx        <= '0;
            zero_flag <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            cvalid    <= 1'b0;
        end else if (!start) begin
            case (state)
                CHECK: begin
                    zero_flag <= (sh_m00 == '0);
                    quo       <= sh_m10;
                    rem       <= '0;
                    cnt       <= CNT_LOAD;
                end
                DIV_X: begin
                    if (cnt == '0) begin
                        qx  <= quo_nxt[XY_W-1:0];
                        quo <= sh_m01;
                        rem <= '0;
                        cnt <= CNT_LOAD;
                    end else begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV_Y: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                UPDATE: begin
                    if (zero_flag) begin
                        cvalid <= 1'b0;
                    end else begin
                        cx     <= qx;
                        cy     <= quo[XY_W-1:0];
                        cvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_marker.sv
module tb_centroid_marker;

    localparam int          XY_W     = 11;
    localparam int          ACC_W    = 34;
    localparam logic [23:0] MARK     = 24'hFF0000;
    localparam int          DIV_LAT  = 2 * ACC_W + 3;
    localparam int          ZERO_LAT = 3;
    localparam int          K_EMPTY  = 0;
    localparam int          K_SINGLE = 1;
    localparam int          K_RECT   = 2;
    localparam int          K_FULL   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
    logic [23:0]     pixel_in = 24'd0;
    logic            de_out, h_sync_out, v_sync_out;
    logic [23:0]     pixel_out;
    logic [XY_W-1:0] centroid_x, centroid_y;
    logic            centroid_valid;

    centroid_marker #(
        .IMG_W(64), .IMG_H(64), .XY_W(XY_W), .ACC_W(ACC_W), .MARK_COLOR(MARK)
    ) dut (
        .clk(clk), .rst(rst),
        .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .pixel_in(pixel_in),
        .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out),
        .centroid_x(centroid_x), .centroid_y(centroid_y), .centroid_valid(centroid_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] pix;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_idx = 0;
    int   mark_cnt = 0;

    // reference model of coordinates, moments and committed centroid
    int              bx, by;
    logic            prev_de, prev_vs, armed;
    longint          m00, m10, m01;
    int              commit_at;
    logic [XY_W-1:0] pend_x, pend_y, mcx, mcy;
    logic            pend_valid, mvalid;

    function automatic void model_reset();
        bx = 0; by = 0; prev_de = 1'b0; prev_vs = 1'b0; armed = 1'b0;
        m00 = 0; m10 = 0; m01 = 0; commit_at = -1;
        pend_x = '0; pend_y = '0; pend_valid = 1'b0;
        mcx = '0; mcy = '0; mvalid = 1'b0;
    endfunction

    function automatic void model_frame_end();
        if (armed) begin
            if (m00 == 0) begin
                pend_valid = 1'b0;
                commit_at  = cyc_idx + 1 + ZERO_LAT;
            end else begin
                pend_x     = XY_W'(m10 / m00);
                pend_y     = XY_W'(m01 / m00);
                pend_valid = 1'b1;
                commit_at  = cyc_idx + 1 + DIV_LAT;
            end
        end
        armed = 1'b1;
        m00 = 0; m10 = 0; m01 = 0;
        bx = 0; by = 0;
    endfunction

    // One clock: check outputs due from the previous cycle, then drive.
    task automatic cyc(input logic de, input logic hs, input logic vs, input logic [23:0] pix);
        exp_t e;
        @(negedge clk);
        cyc_idx++;
        if (commit_at == cyc_idx) begin
            if (pend_valid) begin
                mcx = pend_x;
                mcy = pend_y;
            end
            mvalid    = pend_valid;
            commit_at = -1;
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({de_out, h_sync_out, v_sync_out, pixel_out} !== e) begin
                errors++;
                $display("FAIL stream cyc %0d got de=%b hs=%b vs=%b pix=%h want de=%b hs=%b vs=%b pix=%h",
                         cyc_idx, de_out, h_sync_out, v_sync_out, pixel_out, e.de, e.hs, e.vs, e.pix);
            end
            if (de_out === 1'b1 && pixel_out === MARK) mark_cnt++;
        end
        checks++;
        if ({centroid_valid, centroid_x, centroid_y} !== {mvalid, mcx, mcy}) begin
            errors++;
            $display("FAIL centroid cyc %0d got v=%b x=%0d y=%0d want v=%b x=%0d y=%0d",
                     cyc_idx, centroid_valid, centroid_x, centroid_y, mvalid, mcx, mcy);
        end
        de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = pix;
        e.de  = de;
        e.hs  = hs;
        e.vs  = vs;
        e.pix = (de && mvalid && (bx == int'(mcx) || by == int'(mcy))) ? MARK : pix;
        exp_q.push_back(e);
        if (vs && !prev_vs) begin
            model_frame_end();
        end else if (de) begin
            if (pix != 24'd0) begin
                m00++; m10 += bx; m01 += by;
            end
            bx++;
        end else if (prev_de) begin
            bx = 0;
            by++;
        end
        prev_de = de;
        prev_vs = vs;
    endtask

    function automatic logic in_mask(input int kind, input int x, input int y);
        case (kind)
            K_SINGLE: return (x == 10 && y == 20);
            K_RECT:   return (x >= 8 && x <= 15 && y >= 4 && y <= 7);
            K_FULL:   return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic blank_line_tail();
        for (int i = 0; i < 4; i++) cyc(1'b0, (i == 1 || i == 2), 1'b0, 24'($urandom()));
    endtask

    // v_sync, vertical blank long enough for the divider, then 64x64 active.
    task automatic send_frame(input int kind);
        mark_cnt = 0;
        for (int i = 0; i < 4; i++)  cyc(1'b0, 1'b0, 1'b1, 24'($urandom()));
        for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0, 1'b0, 24'($urandom()));
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 64; x++)
                cyc(1'b1, 1'b0, 1'b0, in_mask(kind, x, y) ? {8'(x), 8'(y), 8'h5A} : 24'd0);
            blank_line_tail();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({de_out, h_sync_out, v_sync_out, pixel_out, centroid_x, centroid_y, centroid_valid} !== '0) begin
            errors++;
            $display("FAIL reset_poweron got de=%b hs=%b vs=%b pix=%h x=%0d y=%0d v=%b want all 0",
                     de_out, h_sync_out, v_sync_out, pixel_out, centroid_x, centroid_y, centroid_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++)  cyc(1'b0, 1'b0, 1'b1, 24'd0);
        for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0, 1'b0, 24'($urandom()));
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
        // assert reset in the middle of an active line
        @(negedge clk);
        rst = 1'b1; de_in = 1'b1; pixel_in = 24'hFFFFFF;
        #1;
        checks++;
        if ({de_out, h_sync_out, v_sync_out, pixel_out} !== '0) begin
            errors++;
            $display("FAIL reset_midline_stream got de=%b hs=%b vs=%b pix=%h want all 0",
                     de_out, h_sync_out, v_sync_out, pixel_out);
        end
        checks++;
        if ({centroid_x, centroid_y, centroid_valid} !== '0) begin
            errors++;
            $display("FAIL reset_midline_centroid got x=%0d y=%0d v=%b want 0 0 0",
                     centroid_x, centroid_y, centroid_valid);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0; de_in = 1'b0; pixel_in = 24'd0;
        // mask data before the first frame end must be discarded
        for (int i = 0; i < 8; i++)  cyc(1'b0, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
        blank_line_tail();
        send_frame(K_SINGLE);
        checks++;
        if (centroid_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard got v=%b want v=0", centroid_valid);
        end
    endtask

    task automatic test_single();
        send_frame(K_RECT);
        checks++;
        if (centroid_x !== 11'd10 || centroid_y !== 11'd20 || centroid_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_centroid got x=%0d y=%0d v=%b want x=10 y=20 v=1",
                     centroid_x, centroid_y, centroid_valid);
        end
        checks++;
        if (mark_cnt !== 127) begin
            errors++;
            $display("FAIL single_marks got %0d want 127", mark_cnt);
        end
    endtask

    task automatic test_rect();
        send_frame(K_FULL);
        checks++;
        if (centroid_x !== 11'd11 || centroid_y !== 11'd5 || centroid_valid !== 1'b1) begin
            errors++;
            $display("FAIL rect_centroid got x=%0d y=%0d v=%b want x=11 y=5 v=1",
                     centroid_x, centroid_y, centroid_valid);
        end
        checks++;
        if (mark_cnt !== 127) begin
            errors++;
            $display("FAIL rect_marks got %0d want 127", mark_cnt);
        end
    endtask

    task automatic test_full();
        send_frame(K_EMPTY);
        checks++;
        if (centroid_x !== 11'd31 || centroid_y !== 11'd31 || centroid_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_centroid got x=%0d y=%0d v=%b want x=31 y=31 v=1",
                     centroid_x, centroid_y, centroid_valid);
        end
    endtask

    task automatic test_empty();
        send_frame(K_SINGLE);
        checks++;
        if (centroid_x !== 11'd31 || centroid_y !== 11'd31 || centroid_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_centroid got x=%0d y=%0d v=%b want x=31 y=31 v=0",
                     centroid_x, centroid_y, centroid_valid);
        end
        checks++;
        if (mark_cnt !== 0) begin
            errors++;
            $display("FAIL empty_marks got %0d want 0", mark_cnt);
        end
    endtask

    task automatic test_abort();
        send_frame(K_RECT);                 // commits the single pixel (10,20)
        // short frame: mask at (4,0) and (5,0); its v_sync lands 10 cycles into DIV_X
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 24'($urandom()));
        for (int x = 0; x < 6; x++) cyc(1'b1, 1'b0, 1'b0, (x >= 4) ? {8'(x), 8'h00, 8'h5A} : 24'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 24'($urandom()));
        checks++;
        if (centroid_x !== 11'd10 || centroid_y !== 11'd20 || centroid_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold got x=%0d y=%0d v=%b want x=10 y=20 v=1",
                     centroid_x, centroid_y, centroid_valid);
        end
        send_frame(K_EMPTY);
        checks++;
        if (centroid_x !== 11'd4 || centroid_y !== 11'd0 || centroid_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_centroid got x=%0d y=%0d v=%b want x=4 y=0 v=1",
                     centroid_x, centroid_y, centroid_valid);
        end
        checks++;
        if (mark_cnt !== 127) begin
            errors++;
            $display("FAIL abort_marks got %0d want 127", mark_cnt);
        end
        for (int i = 0; i < 4; i++)  cyc(1'b0, 1'b0, 1'b1, 24'($urandom()));
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 24'($urandom()));
        checks++;
        if (centroid_x !== 11'd4 || centroid_y !== 11'd0 || centroid_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_empty got x=%0d y=%0d v=%b want x=4 y=0 v=0",
                     centroid_x, centroid_y, centroid_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rect();
        test_full();
        test_empty();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
